fir_stream_source: RTL

- Synthesizable stimulus transmitter for the FIR datapath. It replays a preloaded sample table as a DOUT/VOUT stream into the filter's DIN/VIN inputs.
- Programmable sample count, inter-sample gap and pause.
- After a fixed drain period it raises END_SIM so the clock generator and checkers stop.
- Replaces the file-driven data generator on FPGA and in gate-level runs.

---
 rtl/fir_tb_pkg.sv | 13 +
 rtl/fir_src_mem.sv | 22 ++
 rtl/fir_stream_source.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fir_tb_pkg.sv
// Shared types and constants for the FIR stream source: sample width, gap counter width, FSM states.
package fir_tb_pkg;
  localparam int FIR_DW = 11;
  localparam int GAP_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/fir_src_mem.sv
// Sample table: synchronous write port, combinational read port. Contents are never reset.
module fir_src_mem #(
  parameter int DW = 11,
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_dat,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_dat
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_addr];
endmodule

// File: rtl/fir_stream_source.sv
// Replays a preloaded sample table as a DOUT/VOUT stream with programmable length, gap and pause,
// then raises END_SIM after a drain period. Define FIR_SRC_LOOP_EN to add the LOOP input.
module fir_stream_source
  import fir_tb_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int AW    = 6,
  parameter int DRAIN = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD_EN,
  input  logic [AW-1:0]    LD_ADDR,
  input  logic [DW-1:0]    LD_DATA,
  input  logic [AW:0]      LEN,
  input  logic [GAP_W-1:0] GAP,
  input  logic             START,
  input  logic             PAUSE,
`ifdef FIR_SRC_LOOP_EN
  input  logic             LOOP,
`endif
  output logic [DW-1:0]    DOUT,
  output logic             VOUT,
  output logic             BUSY,
  output logic             END_SIM
);
  localparam int DEPTH = 1 << AW;
  localparam int LEN_W = AW + 1;
  localparam int DCW   = $clog2(DRAIN + 1);

  state_t             r_state;
  logic [DW-1:0]      r_dout;
  logic               r_vout;
  logic               r_busy;
  logic               r_end;
  logic [AW-1:0]      r_ptr;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len;
  logic [GAP_W-1:0]   r_gcnt;
  logic [DCW-1:0]     r_dcnt;

  logic [LEN_W-1:0]   w_len_eff;
  logic               w_last;
  logic               w_loop;
  logic               w_ld_we;
  logic [DW-1:0]      w_rd_dat;

  assign w_len_eff = (LEN > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : LEN;
  assign w_last    = (r_cnt == (r_len - {{AW{1'b0}}, 1'b1}));
  assign w_ld_we   = LD_EN && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef FIR_SRC_LOOP_EN
  assign w_loop = LOOP;
`else
  assign w_loop = 1'b0;
`endif

  fir_src_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .i_clk     (CLK),
    .i_we      (w_ld_we),
    .i_wr_addr (LD_ADDR),
    .i_wr_dat  (LD_DATA),
    .i_rd_addr (r_ptr),
    .o_rd_dat  (w_rd_dat)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_dout  <= '0;
      r_vout  <= 1'b0;
      r_busy  <= 1'b0;
      r_end   <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_gcnt  <= '0;
      r_dcnt  <= '0;
    end else begin
      r_vout <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_len <= w_len_eff;
            if (LEN != '0) begin
              r_state <= S_SEND;
              r_busy  <= 1'b1;
              r_end   <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_end   <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (!PAUSE) begin
            r_dout <= w_rd_dat;
            r_vout <= 1'b1;
            r_ptr  <= r_ptr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
            // A looping pass restarts at entry 0 and keeps the normal inter-sample gap.
            if (w_last && w_loop) begin
              r_ptr <= '0;
              r_cnt <= '0;
              if (GAP != '0) begin
                r_state <= S_GAP;
                r_gcnt  <= GAP;
              end
            end else if (w_last) begin
              r_state <= S_DRAIN;
              r_dcnt  <= '0;
            end else if (GAP != '0) begin
              r_state <= S_GAP;
              r_gcnt  <= GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gcnt == GAP_W'(1)) r_state <= S_SEND;
          else                     r_gcnt  <= r_gcnt - 1'b1;
        end
        S_DRAIN: begin
          if (r_dcnt == DCW'(DRAIN)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_end   <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DOUT    = r_dout;
  assign VOUT    = r_vout;
  assign BUSY    = r_busy;
  assign END_SIM = r_end;
endmodule
